// File: rtl/filter_sequencer.sv
// rtl/filter_sequencer.sv - UART byte assembler, sample FIFO and filter handshake sequencer
module filter_sequencer #(
   parameter int FILT_W     = 33,
   parameter int FIFO_DEPTH = 4,
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 1,
   parameter int TIMEOUT    = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rxByte,
   input  logic              rxValid,
   output logic [FILT_W-1:0] filtIn,
   output logic              filtNewData,
   input  logic [FILT_W-1:0] filtOut,
   input  logic              filtReady,
   output logic [31:0]       resData,
   output logic              resValid,
   input  logic              resReady,
   output logic              busy,
   output logic              overflowErr,
   output logic              timeoutErr,
   output logic [15:0]       sampleCount
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(TIMEOUT + SETUP_CYC + STROBE_CYC + 1);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, HOLD} state_t;

   state_t          state, state_nx;
   logic [1:0]      byte_idx;
   logic [23:0]     partial;
   logic [31:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic [CW-1:0]   cnt;
   logic            ready_q;
   logic            push, wr_en, full, empty, rise;
   logic            pop, cnt_clr, cnt_inc, capture, timeout_hit, transfer;
   logic            unused_filt;

   // only the low 32 bits of the filter result carry data
   assign unused_filt = ^filtOut;

   assign push  = rxValid && (byte_idx == 2'd3);
   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);
   // a full FIFO still accepts a word when the head leaves on the same edge
   assign wr_en = push && (!full || pop);
   // completion is a 0->1 transition, so a level left high from before WAIT is ignored
   assign rise  = filtReady && !ready_q;
   assign busy  = (state != IDLE);

   // byte assembly (MSB first) and FIFO pointer/occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx    <= 2'd0;
         partial     <= 24'd0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overflowErr <= 1'b0;
      end else begin
         if (rxValid) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx != 2'd3)
               partial <= {partial[15:0], rxByte};
         end
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !pop)
            count <= count + 1'b1;
         else if (!wr_en && pop)
            count <= count - 1'b1;
         if (push && !wr_en)
            overflowErr <= 1'b1;
      end
   end

   // FIFO storage, no reset needed since occupancy gates every read
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= {partial, rxByte};
   end

   // sequencer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // next-state and per-edge control decisions
   always_comb begin
      state_nx    = state;
      pop         = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      transfer    = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               cnt_clr  = 1'b1;
               state_nx = SETUP;
            end
         end
         SETUP: begin
            if (cnt == CW'(SETUP_CYC - 1)) begin
               cnt_clr  = 1'b1;
               state_nx = STROBE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         STROBE: begin
            if (cnt == CW'(STROBE_CYC - 1)) begin
               cnt_clr  = 1'b1;
               state_nx = WAIT;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         WAIT: begin
            if (rise) begin
               capture  = 1'b1;
               state_nx = HOLD;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_nx    = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         HOLD: begin
            if (resReady) begin
               transfer = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // filter-side registers, result holding and status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filtIn      <= '0;
         filtNewData <= 1'b0;
         resData     <= 32'd0;
         resValid    <= 1'b0;
         timeoutErr  <= 1'b0;
         sampleCount <= 16'd0;
         ready_q     <= 1'b0;
         cnt         <= '0;
      end else begin
         filtNewData <= (state_nx == STROBE);
         ready_q     <= filtReady;
         if (cnt_clr)
            cnt <= '0;
         else if (cnt_inc)
            cnt <= cnt + 1'b1;
         if (pop)
            filtIn <= FILT_W'(mem[rd_ptr]);
         if (capture) begin
            resData  <= filtOut[31:0];
            resValid <= 1'b1;
         end
         if (transfer) begin
            resValid    <= 1'b0;
            sampleCount <= sampleCount + 16'd1;
         end
         if (timeout_hit)
            timeoutErr <= 1'b1;
      end
   end
endmodule

// File: tb/tb_filter_sequencer.sv
// tb/tb_filter_sequencer.sv - randomized self-checking bench for filter_sequencer
module tb_filter_sequencer;
   localparam int FILT_W = 33;
   localparam int TMO    = 1024;
   localparam logic [31:0] KEY = 32'hFEC2A07E;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        rxByte = 8'd0;
   logic              rxValid = 1'b0;
   logic [FILT_W-1:0] filtIn;
   logic              filtNewData;
   logic [FILT_W-1:0] filtOut = '0;
   logic              filtReady = 1'b0;
   logic [31:0]       resData;
   logic              resValid;
   logic              resReady = 1'b0;
   logic              busy;
   logic              overflowErr;
   logic              timeoutErr;
   logic [15:0]       sampleCount;

   int total = 0;
   int bad = 0;
   int filt_mode = 0;
   int lat_min = 3;
   int lat_max = 3;
   logic man_ready = 1'b0;
   logic [FILT_W-1:0] man_out = '0;
   logic [31:0] mon_loads[$];
   logic [31:0] mon_results[$];

   filter_sequencer #(.FILT_W(FILT_W), .FIFO_DEPTH(4), .SETUP_CYC(2), .STROBE_CYC(1), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .rxByte(rxByte), .rxValid(rxValid),
      .filtIn(filtIn), .filtNewData(filtNewData), .filtOut(filtOut), .filtReady(filtReady),
      .resData(resData), .resValid(resValid), .resReady(resReady), .busy(busy),
      .overflowErr(overflowErr), .timeoutErr(timeoutErr), .sampleCount(sampleCount)
   );

   always #5 clk = ~clk;

   // filter model: mode 0 answers in^KEY after a random latency, 1 never answers, 2 is test-driven
   initial begin : filter_model
      int cd;
      logic nd_prev;
      logic [31:0] held;
      cd = -1;
      nd_prev = 1'b0;
      held = 32'd0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            cd = -1;
            filtReady = 1'b0;
         end else if (filt_mode == 2) begin
            filtReady = man_ready;
            filtOut = man_out;
         end else begin
            filtReady = 1'b0;
            if (filt_mode == 0) begin
               if (filtNewData && !nd_prev) begin
                  cd = $urandom_range(lat_max, lat_min);
                  held = filtIn[31:0];
               end else if (cd > 0) begin
                  cd--;
               end
               if (cd == 0) begin
                  filtReady = 1'b1;
                  filtOut = {1'($urandom_range(1, 0)), held ^ KEY};
                  cd = -1;
               end
            end
         end
         nd_prev = rst ? 1'b0 : filtNewData;
      end
   end

   // monitor: words presented at each strobe and results accepted downstream
   initial begin : monitor
      logic mon_nd;
      mon_nd = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (filtNewData && !mon_nd)
               mon_loads.push_back(filtIn[31:0]);
            if (resValid && resReady)
               mon_results.push_back(resData);
         end
         mon_nd = rst ? 1'b0 : filtNewData;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rxByte = b;
      rxValid = 1'b1;
      tick();
      rxValid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--)
         send_byte(w[8*i +: 8]);
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (resValid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      rxValid = 1'b0;
      resReady = 1'b0;
      man_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      total++;
      if ({filtIn, filtNewData, resData, resValid, busy, overflowErr, timeoutErr, sampleCount} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got filtIn=%h res=%h cnt=%h flags=%b", filtIn, resData, sampleCount,
                  {filtNewData, resValid, busy, overflowErr, timeoutErr});
      end
      apply_reset();
   endtask

   task automatic test_single_sample();
      bit ok;
      apply_reset();
      filt_mode = 0; lat_min = 3; lat_max = 3;
      resReady = 1'b1;
      send_byte(8'hBF); send_byte(8'h83); send_byte(8'hC6); send_byte(8'hE0);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_E0 got=%b want=0", busy); end
      tick();
      total++;
      if (filtIn !== 33'h0BF83C6E0) begin bad++; $display("FAIL single_filtIn got=%h want=0bf83c6e0", filtIn); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_E1 got=%b want=1", busy); end
      for (int e = 2; e <= 4; e++) begin
         if (e > 1) tick();
         total++;
         if (filtNewData !== (e == 3)) begin
            bad++;
            $display("FAIL single_strobe_E%0d got=%b want=%b", e, filtNewData, (e == 3));
         end
      end
      wait_valid(40, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL single_wait got=no_resValid want=resValid"); end
      total++;
      if (resData !== 32'h4141669E) begin bad++; $display("FAIL single_resData got=%h want=4141669e", resData); end
      tick();
      total++;
      if ({resValid, busy, sampleCount} !== {1'b0, 1'b0, 16'd1}) begin
         bad++;
         $display("FAIL single_transfer got v=%b busy=%b cnt=%0d want 0 0 1", resValid, busy, sampleCount);
      end
   endtask

   task automatic test_burst_overflow();
      logic [31:0] w[6];
      apply_reset();
      filt_mode = 1;
      resReady = 1'b1;
      foreach (w[i]) w[i] = $urandom;
      for (int i = 0; i < 5; i++) send_word(w[i]);
      total++;
      if (overflowErr !== 1'b0) begin bad++; $display("FAIL burst_no_ovf_yet got=%b want=0", overflowErr); end
      send_word(w[5]);
      total++;
      if (overflowErr !== 1'b1) begin bad++; $display("FAIL burst_ovf got=%b want=1", overflowErr); end
      total++;
      if (filtIn !== {1'b0, w[0]}) begin bad++; $display("FAIL burst_first got=%h want=%h", filtIn, w[0]); end
      // w[0] loaded on the edge of w[1]'s first byte; 19 edges have passed since then
      repeat (TMO + 2 - 19) tick();
      total++;
      if ({timeoutErr, busy} !== 2'b01) begin
         bad++;
         $display("FAIL burst_pre_timeout got tmo=%b busy=%b want 0 1", timeoutErr, busy);
      end
      tick();
      total++;
      if ({timeoutErr, busy} !== 2'b10) begin
         bad++;
         $display("FAIL burst_timeout got tmo=%b busy=%b want 1 0", timeoutErr, busy);
      end
      tick();
      total++;
      if (filtIn !== {1'b0, w[1]} || busy !== 1'b1) begin
         bad++;
         $display("FAIL burst_next_load got=%h busy=%b want=%h 1", filtIn, busy, w[1]);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [31:0] wa, wb, hold;
      logic [FILT_W-1:0] fi;
      apply_reset();
      filt_mode = 0; lat_min = 1; lat_max = 6;
      resReady = 1'b0;
      wa = $urandom; wb = $urandom;
      send_word(wa);
      send_word(wb);
      wait_valid(60, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL bp_wait got=no_resValid want=resValid"); end
      total++;
      if (resData !== (wa ^ KEY)) begin bad++; $display("FAIL bp_data got=%h want=%h", resData, wa ^ KEY); end
      hold = resData;
      fi = filtIn;
      for (int i = 0; i < 20; i++) begin
         tick();
         total++;
         if (resValid !== 1'b1 || resData !== hold || busy !== 1'b1 || filtIn !== fi || sampleCount !== 16'd0) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d got v=%b d=%h busy=%b in=%h cnt=%0d want 1 %h 1 %h 0",
                     i, resValid, resData, busy, filtIn, sampleCount, hold, fi);
         end
      end
      resReady = 1'b1;
      tick();
      total++;
      if (resValid !== 1'b0 || sampleCount !== 16'd1) begin
         bad++;
         $display("FAIL bp_release got v=%b cnt=%0d want 0 1", resValid, sampleCount);
      end
      wait_valid(60, ok);
      total++;
      if (!ok || resData !== (wb ^ KEY)) begin
         bad++;
         $display("FAIL bp_second got=%h ok=%b want=%h", resData, ok, wb ^ KEY);
      end
      tick();
      total++;
      if (sampleCount !== 16'd2) begin bad++; $display("FAIL bp_count got=%0d want=2", sampleCount); end
   endtask

   task automatic test_stuck_high();
      logic [31:0] ws;
      apply_reset();
      filt_mode = 2;
      man_ready = 1'b1;
      man_out = {1'b1, 32'h23456789};
      resReady = 1'b1;
      ws = $urandom;
      tick();
      send_word(ws);
      repeat (12) tick();
      total++;
      if (resValid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL stuck_no_capture got v=%b busy=%b want 0 1", resValid, busy);
      end
      man_ready = 1'b0;
      tick();
      total++;
      if (resValid !== 1'b0) begin bad++; $display("FAIL stuck_low got v=%b want=0", resValid); end
      man_ready = 1'b1;
      tick();
      total++;
      if (resValid !== 1'b1 || resData !== 32'h23456789) begin
         bad++;
         $display("FAIL stuck_rise got v=%b d=%h want 1 23456789", resValid, resData);
      end
      tick();
      total++;
      if (sampleCount !== 16'd1) begin bad++; $display("FAIL stuck_count got=%0d want=1", sampleCount); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      apply_reset();
      filt_mode = 1;
      resReady = 1'b1;
      send_word($urandom); send_word($urandom); send_word($urandom);
      send_byte(8'hAA); send_byte(8'h55);
      tick();
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", busy); end
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      total++;
      if ({filtIn, filtNewData, resData, resValid, busy, overflowErr, timeoutErr, sampleCount} !== '0) begin
         bad++;
         $display("FAIL mid_async_reset got filtIn=%h busy=%b", filtIn, busy);
      end
      tick();
      rst = 1'b0;
      filt_mode = 0; lat_min = 2; lat_max = 2;
      repeat (3) tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL mid_fifo_empty got busy=%b want=0", busy); end
      send_word(32'h40039B58);
      tick();
      total++;
      if (filtIn !== 33'h040039B58) begin bad++; $display("FAIL mid_fresh_word got=%h want=040039b58", filtIn); end
      wait_valid(40, ok);
      total++;
      if (!ok || resData !== (32'h40039B58 ^ KEY)) begin
         bad++;
         $display("FAIL mid_result got=%h ok=%b want=%h", resData, ok, 32'h40039B58 ^ KEY);
      end
      repeat (6) tick();
      total++;
      if (busy !== 1'b0 || sampleCount !== 16'd1) begin
         bad++;
         $display("FAIL mid_after got busy=%b cnt=%0d want 0 1", busy, sampleCount);
      end
   endtask

   task automatic test_random_stream();
      localparam int N = 40;
      logic [31:0] exp_words[$];
      logic [31:0] cur;
      int bidx, sent, nl, nr;
      apply_reset();
      filt_mode = 0; lat_min = 1; lat_max = 8;
      mon_loads.delete();
      mon_results.delete();
      bidx = -1;
      sent = 0;
      cur = 32'd0;
      for (int cyc = 0; cyc < 8000 && mon_results.size() < N; cyc++) begin
         resReady = ($urandom_range(3, 0) != 0);
         rxValid = 1'b0;
         if (bidx < 0 && sent < N && (sent - mon_results.size()) < 4) begin
            cur = $urandom;
            exp_words.push_back(cur);
            sent++;
            bidx = 0;
         end
         if (bidx >= 0 && $urandom_range(2, 0) != 0) begin
            rxByte = cur[31 - 8*bidx -: 8];
            rxValid = 1'b1;
            bidx++;
            if (bidx == 4) bidx = -1;
         end
         tick();
      end
      rxValid = 1'b0;
      resReady = 1'b0;
      nl = mon_loads.size();
      nr = mon_results.size();
      total++;
      if (nl != N || nr != N) begin bad++; $display("FAIL rand_counts got loads=%0d results=%0d want=%0d", nl, nr, N); end
      for (int i = 0; i < N && i < nl && i < nr; i++) begin
         total++;
         if (mon_loads[i] !== exp_words[i] || mon_results[i] !== (exp_words[i] ^ KEY)) begin
            bad++;
            $display("FAIL rand_item%0d got load=%h res=%h want %h %h", i, mon_loads[i], mon_results[i],
                     exp_words[i], exp_words[i] ^ KEY);
         end
      end
      total++;
      if (sampleCount !== 16'(N) || overflowErr !== 1'b0 || timeoutErr !== 1'b0) begin
         bad++;
         $display("FAIL rand_status got cnt=%0d ovf=%b tmo=%b want %0d 0 0", sampleCount, overflowErr, timeoutErr, N);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      logic [15:0] want;
      apply_reset();
      filt_mode = 0; lat_min = 1; lat_max = 3;
      resReady = 1'b1;
      force dut.sampleCount = 16'hFFFE;
      tick();
      release dut.sampleCount;
      tick();
      total++;
      if (sampleCount !== 16'hFFFE) begin bad++; $display("FAIL wrap_preload got=%h want=fffe", sampleCount); end
      want = 16'hFFFE;
      for (int k = 0; k < 2; k++) begin
         want = want + 16'd1;
         send_word($urandom);
         wait_valid(40, ok);
         tick();
         total++;
         if (!ok || sampleCount !== want) begin
            bad++;
            $display("FAIL wrap_step%0d got=%h ok=%b want=%h", k, sampleCount, ok, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_sample();
      test_burst_overflow();
      test_backpressure();
      test_stuck_high();
      test_reset_mid();
      test_random_stream();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
